// File: rtl/freq_meas_if.sv
// freq_meas_if: command and result bundle between the Nios-side control and the measurement sequencer
interface freq_meas_if #(parameter int CNT_W = 32);
    logic             start;
    logic             abort;
    logic             sig_in;
    logic [CNT_W-1:0] freq_base;
    logic [4:0]       time_del;
    logic [CNT_W-1:0] timeout_cyc;
    logic             busy;
    logic             gate;
    logic             done;
    logic             result_valid;
    logic             timeout_err;
    logic [CNT_W-1:0] cnt_ref;
    logic [CNT_W-1:0] cnt_sig;
    modport master (
        output start, abort, sig_in, freq_base, time_del, timeout_cyc,
        input  busy, gate, done, result_valid, timeout_err, cnt_ref, cnt_sig
    );
    modport slave (
        input  start, abort, sig_in, freq_base, time_del, timeout_cyc,
        output busy, gate, done, result_valid, timeout_err, cnt_ref, cnt_sig
    );
endinterface

// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: reciprocal gated-count sequencer; gate opens and closes on signal rising edges
module freq_meas_ctrl #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    freq_meas_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ARM, GATE, CLOSE, DONE} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sync;
    logic sig_d, sig_rise, gate_full, close_now, timed_out;
    logic [CNT_W-1:0] gate_len, elapsed, sig_w, timer;
    logic [CNT_W-1:0] shifted, elapsed_inc, sig_w_inc, timer_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // bring sig_in into the clk domain and keep the previous synchronized value for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            sig_d <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], bus.sig_in};
            sig_d <= sync[SYNC_STAGES-1];
        end
    end

    // elapsed counts clocks since the opening edge, so the current cycle's value is the register plus one
    always_comb begin
        sig_rise    = sync[SYNC_STAGES-1] & ~sig_d;
        shifted     = bus.freq_base >> bus.time_del;
        elapsed_inc = sat_inc(elapsed);
        sig_w_inc   = sig_rise ? sat_inc(sig_w) : sig_w;
        timer_inc   = sat_inc(timer);
        gate_full   = elapsed_inc >= gate_len;
        close_now   = sig_rise && gate_full;
        timed_out   = (bus.timeout_cyc != '0) && (timer_inc >= bus.timeout_cyc);
    end

    // measurement FSM with registered status outputs and result latching
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            gate_len         <= '0;
            elapsed          <= '0;
            sig_w            <= '0;
            timer            <= '0;
            bus.busy         <= 1'b0;
            bus.gate         <= 1'b0;
            bus.done         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.timeout_err  <= 1'b0;
            bus.cnt_ref      <= '0;
            bus.cnt_sig      <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state            <= ARM;
                        bus.busy         <= 1'b1;
                        gate_len         <= (shifted == '0) ? CNT_W'(1) : shifted;
                        bus.timeout_err  <= 1'b0;
                        bus.result_valid <= 1'b0;
                        elapsed          <= '0;
                        sig_w            <= '0;
                        timer            <= '0;
                    end
                end
                ARM: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (sig_rise) begin
                        state    <= GATE;
                        bus.gate <= 1'b1;
                        elapsed  <= '0;
                        sig_w    <= '0;
                    end else if (timed_out) begin
                        state            <= DONE;
                        bus.done         <= 1'b1;
                        bus.timeout_err  <= 1'b1;
                        bus.result_valid <= 1'b0;
                        bus.cnt_ref      <= '0;
                        bus.cnt_sig      <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                GATE, CLOSE: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.gate <= 1'b0;
                    end else if (close_now) begin
                        state            <= DONE;
                        bus.gate         <= 1'b0;
                        bus.done         <= 1'b1;
                        bus.result_valid <= 1'b1;
                        bus.cnt_ref      <= elapsed_inc;
                        bus.cnt_sig      <= sig_w_inc;
                    end else begin
                        elapsed <= elapsed_inc;
                        sig_w   <= sig_w_inc;
                        if (state == GATE) begin
                            if (gate_full) begin
                                state <= CLOSE;
                                timer <= '0;
                            end
                        end else if (timed_out) begin
                            state            <= DONE;
                            bus.gate         <= 1'b0;
                            bus.done         <= 1'b1;
                            bus.timeout_err  <= 1'b1;
                            bus.result_valid <= 1'b0;
                            bus.cnt_ref      <= '0;
                            bus.cnt_sig      <= '0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.gate <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl: directed scenarios for the frequency measurement sequencer
module tb_freq_meas_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vec = 0;
    int bad = 0;
    int period = 0;
    int ph = 0;
    int done_cnt, gate_cyc, done_at;

    freq_meas_if bus ();
    freq_meas_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // periodic measured signal: one rising edge every `period` clocks, held low when period is 0
    initial begin
        bus.sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (period == 0) begin
                ph = 0;
                bus.sig_in = 1'b0;
            end else begin
                ph = (ph + 1 >= period) ? 0 : ph + 1;
                bus.sig_in = (ph < period / 2);
            end
        end
    end

    task automatic start_meas(input logic [31:0] fb, input logic [4:0] td, input logic [31:0] to);
        bus.freq_base = fb;
        bus.time_del = td;
        bus.timeout_cyc = to;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic collect(input int maxc);
        done_cnt = 0;
        gate_cyc = 0;
        done_at = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (bus.gate) gate_cyc++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (done_at >= 0 && i >= done_at + 5) break;
        end
    endtask

    task automatic run(input logic [31:0] fb, input logic [4:0] td, input logic [31:0] to, input int maxc);
        start_meas(fb, td, to);
        collect(maxc);
    endtask

    task automatic wait_gate(input int maxc);
        for (int i = 0; i < maxc && bus.gate !== 1'b1; i++) @(negedge clk);
        vec++;
        if (bus.gate !== 1'b1) begin
            bad++;
            $display("FAIL wait_gate: gate=%b, required 1 within %0d cycles", bus.gate, maxc);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vec++;
        if ({bus.busy, bus.gate, bus.done, bus.result_valid, bus.timeout_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {bus.busy, bus.gate, bus.done, bus.result_valid, bus.timeout_err});
        end
        vec++;
        if (bus.cnt_ref !== 32'd0 || bus.cnt_sig !== 32'd0) begin
            bad++;
            $display("FAIL reset_counts: cnt_ref=%0d cnt_sig=%0d, required 0 0", bus.cnt_ref, bus.cnt_sig);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vec++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        period = 10;
        repeat (20) @(negedge clk);
        run(100, 0, 0, 400);
        vec++;
        if (done_cnt != 1) begin bad++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt); end
        vec++;
        if (gate_cyc < 100 || gate_cyc > 101) begin bad++; $display("FAIL basic_gate_len: got %0d, required 100..101", gate_cyc); end
        vec++;
        if (bus.cnt_ref !== 32'd100 || bus.cnt_sig !== 32'd10) begin
            bad++;
            $display("FAIL basic_counts: cnt_ref=%0d cnt_sig=%0d, required 100 10", bus.cnt_ref, bus.cnt_sig);
        end
        vec++;
        if (bus.result_valid !== 1'b1 || bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_flags: valid=%b terr=%b busy=%b, required 1 0 0", bus.result_valid, bus.timeout_err, bus.busy);
        end
    endtask

    task automatic test_short_gate();
        run(380, 2, 0, 400);
        vec++;
        if (bus.cnt_ref !== 32'd100 || bus.cnt_sig !== 32'd10 || bus.result_valid !== 1'b1) begin
            bad++;
            $display("FAIL shift_gate: cnt_ref=%0d cnt_sig=%0d valid=%b, required 100 10 1", bus.cnt_ref, bus.cnt_sig, bus.result_valid);
        end
        run(0, 0, 0, 400);
        vec++;
        if (bus.cnt_ref !== 32'd10 || bus.cnt_sig !== 32'd1 || done_cnt != 1) begin
            bad++;
            $display("FAIL min_gate: cnt_ref=%0d cnt_sig=%0d done=%0d, required 10 1 1", bus.cnt_ref, bus.cnt_sig, done_cnt);
        end
    endtask

    task automatic test_timeout();
        period = 0;
        repeat (5) @(negedge clk);
        run(100, 0, 50, 200);
        vec++;
        if (done_cnt != 1 || done_at < 49 || done_at > 53) begin
            bad++;
            $display("FAIL arm_timeout_done: count=%0d at=%0d, required 1 at 49..53", done_cnt, done_at);
        end
        vec++;
        if (gate_cyc != 0) begin bad++; $display("FAIL arm_timeout_gate: got %0d gate cycles, required 0", gate_cyc); end
        vec++;
        if (bus.timeout_err !== 1'b1 || bus.result_valid !== 1'b0 || bus.cnt_ref !== 32'd0 || bus.cnt_sig !== 32'd0) begin
            bad++;
            $display("FAIL arm_timeout_result: terr=%b valid=%b cnt_ref=%0d cnt_sig=%0d, required 1 0 0 0",
                     bus.timeout_err, bus.result_valid, bus.cnt_ref, bus.cnt_sig);
        end
    endtask

    task automatic test_close_timeout();
        period = 10;
        repeat (20) @(negedge clk);
        start_meas(95, 0, 40);
        wait_gate(100);
        repeat (50) @(negedge clk);
        period = 0;
        collect(300);
        vec++;
        if (done_cnt != 1 || bus.timeout_err !== 1'b1 || bus.result_valid !== 1'b0 || bus.cnt_ref !== 32'd0) begin
            bad++;
            $display("FAIL close_timeout: done=%0d terr=%b valid=%b cnt_ref=%0d, required 1 1 0 0",
                     done_cnt, bus.timeout_err, bus.result_valid, bus.cnt_ref);
        end
        period = 7;
        repeat (20) @(negedge clk);
        run(100, 0, 40, 400);
        vec++;
        if (bus.timeout_err !== 1'b0 || bus.result_valid !== 1'b1) begin
            bad++;
            $display("FAIL p7_flags: terr=%b valid=%b, required 0 1", bus.timeout_err, bus.result_valid);
        end
        vec++;
        if (bus.cnt_ref !== 32'd105 || bus.cnt_sig !== 32'd15) begin
            bad++;
            $display("FAIL p7_counts: cnt_ref=%0d cnt_sig=%0d, required 105 15", bus.cnt_ref, bus.cnt_sig);
        end
    endtask

    task automatic test_abort();
        period = 10;
        start_meas(1000, 0, 0);
        wait_gate(60);
        repeat (30) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        vec++;
        if (bus.gate !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: gate=%b busy=%b, required 0 0", bus.gate, bus.busy);
        end
        collect(20);
        vec++;
        if (done_cnt != 0 || bus.result_valid !== 1'b0 || bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: done=%0d valid=%b terr=%b, required 0 0 0", done_cnt, bus.result_valid, bus.timeout_err);
        end
        bus.freq_base = 100;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        vec++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_abort_same: busy=%b, required 0", bus.busy); end
        @(negedge clk);
        vec++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_abort_later: busy=%b, required 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        period = 10;
        start_meas(100, 0, 0);
        wait_gate(60);
        repeat (20) @(negedge clk);
        bus.freq_base = 30;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        collect(300);
        vec++;
        if (done_cnt != 1 || bus.cnt_ref !== 32'd100 || bus.cnt_sig !== 32'd10 || bus.result_valid !== 1'b1) begin
            bad++;
            $display("FAIL restart_ignored: done=%0d cnt_ref=%0d cnt_sig=%0d valid=%b, required 1 100 10 1",
                     done_cnt, bus.cnt_ref, bus.cnt_sig, bus.result_valid);
        end
    endtask

    task automatic test_reset_in_close();
        start_meas(95, 0, 0);
        wait_gate(60);
        repeat (96) @(negedge clk);
        vec++;
        if (bus.gate !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL close_gate_open: gate=%b done=%b, required 1 0", bus.gate, bus.done);
        end
        #2 reset = 1'b1;
        #1;
        vec++;
        if ({bus.busy, bus.gate, bus.done, bus.result_valid, bus.timeout_err} !== 5'b0 ||
            bus.cnt_ref !== 32'd0 || bus.cnt_sig !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: flags=%b cnt_ref=%0d cnt_sig=%0d, required 00000 0 0",
                     {bus.busy, bus.gate, bus.done, bus.result_valid, bus.timeout_err}, bus.cnt_ref, bus.cnt_sig);
        end
        @(negedge clk);
        reset = 1'b0;
        collect(20);
        vec++;
        if (done_cnt != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: done=%0d busy=%b, required 0 0", done_cnt, bus.busy);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.freq_base = '0;
        bus.time_del = '0;
        bus.timeout_cyc = '0;
        test_reset();
        test_basic();
        test_short_gate();
        test_timeout();
        test_close_timeout();
        test_abort();
        test_back_to_back();
        test_reset_in_close();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
Measurement sequencer for the frequency meter. It runs one reciprocal (edge-aligned) gated count per software start command. The gate opens on a rising edge of the measured signal and stays open for at least gate_len = freq_base >> time_del reference clocks. It closes on the first signal rising edge after that, then latches the reference-clock count and signal-edge count for the Nios register interface. It owns the gate and the result handshake that the reference/test counters depend on.

Parameters:
CNT_W, 32, width of gate length, working counters, timeout and result registers
SYNC_STAGES, 2, synchronizer flops on sig_in (minimum 2)

Ports:
clk  in  1  reference clock; all counting in this domain
reset  in  1  asynchronous, active-high; clock is clk
start  in  1  1-cycle request to begin a measurement
abort  in  1  cancel the measurement in progress
sig_in  in  1  measured signal, asynchronous to clk
freq_base  in  CNT_W  reference count for the full-length gate
time_del  in  5  right-shift applied to freq_base to shorten the gate
timeout_cyc  in  CNT_W  maximum clk cycles to wait for an edge; 0 = no timeout
busy  out  1  high in every state except IDLE
gate  out  1  high while counting (GATE and CLOSE)
done  out  1  1-cycle pulse at the end of a measurement (normal or timeout)
result_valid  out  1  cnt_ref/cnt_sig hold a valid completed measurement
timeout_err  out  1  last measurement ended by timeout
cnt_ref  out  CNT_W  latched clk cycles between opening and closing edges
cnt_sig  out  CNT_W  latched signal rising edges after the opening edge, closing edge included

Behaviour:
- Reset: state IDLE; busy, gate, done, result_valid, timeout_err = 0; cnt_ref, cnt_sig = 0; synchronizer flops = 0.
- sig_in passes through SYNC_STAGES flops. sig_rise = last stage 1 and previous-cycle value 0. Edge-to-sig_rise latency is SYNC_STAGES+1 cycles, fixed.
- States: IDLE, ARM, GATE, CLOSE, DONE.
- IDLE: on start (with abort low), go to ARM next cycle.
  - freq_base and time_del are sampled at start only.
  - gate_len = freq_base >> time_del. If gate_len is 0, it is forced to 1.
  - Clear timeout_err, result_valid, working counters and timer.
- ARM: wait for sig_rise, then go to GATE. The sig_rise cycle is the opening edge (elapsed = 0).
  - The timer counts ARM cycles. If timeout_cyc != 0 and the timer reaches timeout_cyc, go to DONE with timeout.
- GATE: gate = 1. elapsed increments by 1 every clk. sig_w increments on each sig_rise.
  - When elapsed reaches gate_len, go to CLOSE.
  - The timer is not checked in GATE.
- CLOSE: gate = 1; counting continues. The timer restarts on entry.
  - The first sig_rise at elapsed >= gate_len is the closing edge. On that edge: cnt_ref = elapsed, cnt_sig = sig_w including the closing edge, result_valid = 1, go to DONE.
  - Timeout works as in ARM.
- Edge at exactly elapsed == gate_len closes the gate in that cycle. The GATE->CLOSE transition and the close occur together.
- DONE: exactly one cycle; done = 1, gate = 0. Next state is IDLE.
  - On timeout: timeout_err = 1, result_valid = 0, cnt_ref/cnt_sig = 0.
- Invariant for a steady signal of period P clks: cnt_ref = cnt_sig * P.
- start while busy is ignored; no restart and no queueing.
- abort in ARM, GATE or CLOSE: go to IDLE next cycle; gate drops, no done pulse.
  - result_valid and timeout_err are not set; they remain 0, as cleared at start.
- abort and start in the same IDLE cycle: abort wins, stay in IDLE.
- Working counters saturate at all-ones; they never wrap.
- reset mid-measurement: immediate return to the reset state; no done.
- Outputs are registered; gate/busy change the cycle after the triggering state transition.

Test Plan:
- sig_in period 10 clk, freq_base=100, time_del=0, timeout_cyc=0, start -> gate high ≥100 cycles; done pulse once; cnt_ref=100, cnt_sig=10, result_valid=1, timeout_err=0.
- Same signal, freq_base=380, time_del=2 (gate_len 95) -> closes at next edge: cnt_ref=100, cnt_sig=10; repeat with freq_base=0 -> gate_len forced 1, cnt_ref=10, cnt_sig=1.
- sig_in held 0, timeout_cyc=50, start -> done exactly once about 51 cycles after start; timeout_err=1, result_valid=0, cnt_ref=cnt_sig=0, gate never high.
- Signal stops mid-CLOSE, timeout_cyc=40 -> timeout done; then signal period 7, new start -> timeout_err cleared, cnt_ref=7*cnt_sig.
- abort asserted 30 cycles into GATE -> IDLE next cycle, gate low, no done, result_valid=0; start+abort same cycle in IDLE -> busy stays 0.
- start pulsed again during GATE, and async reset asserted during CLOSE -> second start has no effect and results match the first measurement; reset forces all outputs 0 immediately.
